// File: rtl/rvx_od_io_pkg.sv
// Shared constants and helpers for the open-drain pad controller.
package rvx_od_io_pkg;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic OD_MODE    = 1'b1;
    localparam logic PP_MODE    = 1'b0;

    // Width of a counter that must hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/od_io_channel.sv
// One pad channel: registered drive, input synchroniser, glitch filter,
// edge pulses and sticky stuck-low detector.
module od_io_channel
    import rvx_od_io_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3,
    parameter int STUCK_CYCLES  = 1024
) (
    input  logic clk,
    input  logic rstnn,
    input  logic od_mode,
    input  logic oe,
    input  logic out_val,
    input  logic pad_in,
    input  logic stuck_clear,
    output logic drive_en,
    output logic drive_val,
    output logic in_val,
    output logic rise,
    output logic fall,
    output logic stuck
);

    localparam int FW = cnt_width(FILTER_CYCLES);
    localparam int SW = cnt_width(STUCK_CYCLES);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;
    logic                   filt_nxt;
    logic [SW-1:0]          stuck_cnt;
    logic                   expect_high;
    logic                   stuck_cond;
    logic                   stuck_sat;
    logic                   stuck_set;

    // Open-drain only ever pulls low, so drive_val is forced to 0 there; this
    // also keeps a push-pull-high to open-drain switch from ever driving 1.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            drive_en  <= 1'b0;
            drive_val <= 1'b0;
        end else begin
            drive_en  <= (od_mode == OD_MODE) ? ~out_val : oe;
            drive_val <= (od_mode == PP_MODE) & out_val;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            sync <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pad_in};
        end
    end

    assign sync_out = sync[SYNC_STAGES-1];

    generate
        if (FILTER_CYCLES == 0) begin : g_bypass
            assign filt_nxt = sync_out;
        end else begin : g_filter
            logic [FW-1:0] filt_cnt;
            logic          filt_done;

            assign filt_done = (sync_out != in_val) && (filt_cnt == FW'(FILTER_CYCLES - 1));
            assign filt_nxt  = filt_done ? sync_out : in_val;

            always_ff @(posedge clk or negedge rstnn) begin
                if (!rstnn) begin
                    filt_cnt <= '0;
                end else if (sync_out == in_val || filt_done) begin
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            in_val <= IDLE_LEVEL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            in_val <= filt_nxt;
            rise   <= filt_nxt & ~in_val;
            fall   <= ~filt_nxt & in_val;
        end
    end

    assign expect_high = ~drive_en | drive_val;
    assign stuck_cond  = expect_high & ~in_val;
    assign stuck_sat   = (stuck_cnt == SW'(STUCK_CYCLES));
    // Set on the reaching edge, and again one cycle after a clear if still saturated.
    assign stuck_set   = stuck_cond &
                         ((stuck_cnt == SW'(STUCK_CYCLES - 1)) | (stuck_sat & ~stuck));

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            stuck_cnt <= '0;
            stuck     <= 1'b0;
        end else begin
            if (!stuck_cond) begin
                stuck_cnt <= '0;
            end else if (!stuck_sat) begin
                stuck_cnt <= stuck_cnt + 1'b1;
            end
            stuck <= stuck_set | (stuck & ~stuck_clear);
        end
    end

endmodule

// File: rtl/open_drain_io_ctrl.sv
// Open-drain / push-pull pad controller for NUM_CHANNEL independent lines;
// one od_io_channel per line, pads resolved here.
module open_drain_io_ctrl
    import rvx_od_io_pkg::*;
#(
    parameter int NUM_CHANNEL   = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3,
    parameter int STUCK_CYCLES  = 1024
) (
    input  logic                   clk,
    input  logic                   rstnn,
    input  logic [NUM_CHANNEL-1:0] od_mode_list,
    input  logic [NUM_CHANNEL-1:0] oe_list,
    input  logic [NUM_CHANNEL-1:0] out_val_list,
    output logic [NUM_CHANNEL-1:0] in_val_list,
    output logic [NUM_CHANNEL-1:0] rise_list,
    output logic [NUM_CHANNEL-1:0] fall_list,
    input  logic [NUM_CHANNEL-1:0] stuck_clear_list,
    output logic [NUM_CHANNEL-1:0] stuck_list,
    inout  wire  [NUM_CHANNEL-1:0] inout_port_list
);

    logic [NUM_CHANNEL-1:0] drive_en;
    logic [NUM_CHANNEL-1:0] drive_val;

    for (genvar i = 0; i < NUM_CHANNEL; i++) begin : g_ch
        od_io_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .STUCK_CYCLES (STUCK_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rstnn      (rstnn),
            .od_mode    (od_mode_list[i]),
            .oe         (oe_list[i]),
            .out_val    (out_val_list[i]),
            .pad_in     (inout_port_list[i]),
            .stuck_clear(stuck_clear_list[i]),
            .drive_en   (drive_en[i]),
            .drive_val  (drive_val[i]),
            .in_val     (in_val_list[i]),
            .rise       (rise_list[i]),
            .fall       (fall_list[i]),
            .stuck      (stuck_list[i])
        );

        assign inout_port_list[i] = drive_en[i] ? drive_val[i] : 1'bz;
    end

endmodule

// File: tb/tb_open_drain_io_ctrl.sv
// Bench for open_drain_io_ctrl: drive-path vector table, hand-written
// filter/stuck/reset sequences, then random traffic against a history-based model.
module tb_open_drain_io_ctrl;

    localparam int NCH  = 4;
    localparam int SYNC = 2;
    localparam int FILT = 3;
    localparam int STK  = 1024;
    localparam int HD   = SYNC + FILT;

    logic           clk = 1'b0;
    logic           rstnn;
    logic [NCH-1:0] od_mode, oe, out_val, stuck_clear, ext_low;
    wire  [NCH-1:0] in_val, rise, fall, stuck;
    wire  [NCH-1:0] pads;

    int n_checks = 0;
    int n_pass   = 0;

    open_drain_io_ctrl #(
        .NUM_CHANNEL(NCH), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .STUCK_CYCLES(STK)
    ) dut (
        .clk             (clk),
        .rstnn           (rstnn),
        .od_mode_list    (od_mode),
        .oe_list         (oe),
        .out_val_list    (out_val),
        .in_val_list     (in_val),
        .rise_list       (rise),
        .fall_list       (fall),
        .stuck_clear_list(stuck_clear),
        .stuck_list      (stuck),
        .inout_port_list (pads)
    );

    for (genvar g = 0; g < NCH; g++) begin : g_pad
        pullup pu (pads[g]);
        assign pads[g] = ext_low[g] ? 1'b0 : 1'bz;
    end

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    // hist bit k holds the pad level sampled k edges ago.
    logic [HD-1:0]  hist [NCH];
    logic [NCH-1:0] m_filt, m_rise, m_fall, m_stuck, prev_out;
    int             run [NCH];

    task automatic model_init();
        for (int c = 0; c < NCH; c++) begin
            hist[c] = '1;
            run[c]  = 0;
        end
        m_filt = '1; m_rise = '0; m_fall = '0; m_stuck = '0; prev_out = '1;
    endtask

    task automatic model_step(input int c, input logic p, input logic eh);
        logic cond, flip;
        cond    = eh && !m_filt[c];
        hist[c] = {hist[c][HD-2:0], p};
        flip    = 1'b1;
        for (int k = SYNC; k < SYNC + FILT; k++)
            if (hist[c][k] == m_filt[c]) flip = 1'b0;
        m_rise[c] = flip && !m_filt[c];
        m_fall[c] = flip && m_filt[c];
        if (flip) m_filt[c] = ~m_filt[c];
        run[c] = cond ? ((run[c] < STK) ? run[c] + 1 : STK) : 0;
        if (run[c] == STK) m_stuck[c] = 1'b1;
    endtask

    task automatic do_reset();
        rstnn = 1'b0;
        repeat (3) @(negedge clk);
        rstnn = 1'b1;
    endtask

    // Watch one channel for n cycles; report first/number of fall and rise pulses.
    task automatic watch(input int ch, input int n, output int f_at, output int f_n,
                         output int r_at, output int r_n, output int both);
        f_at = -1; r_at = -1; f_n = 0; r_n = 0; both = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (fall[ch]) begin f_n++; if (f_at < 0) f_at = k; end
            if (rise[ch]) begin r_n++; if (r_at < 0) r_at = k; end
            if (fall[ch] && rise[ch]) both++;
        end
    endtask

    typedef struct {
        logic od;
        logic oe;
        logic out_val;
        logic exp_pad;
        logic exp_en;
        logic exp_val;
    } drv_vec_t;

    initial begin
        drv_vec_t tbl[9];
        int f_at, f_n, r_at, r_n, both, lows, seen, set_cnt;

        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        od_mode = '1; oe = '0; out_val = '1; stuck_clear = '0; ext_low = '0;
        rstnn = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_val", in_val, 4'hF);
        chk("rst_rise", rise, 0);
        chk("rst_fall", fall, 0);
        chk("rst_stuck", stuck, 0);
        chk("rst_drive_en", dut.drive_en, 0);
        chk("rst_pads", pads, 4'hF);
        rstnn = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rise != 0 || fall != 0 || in_val != 4'hF) seen++;
        end
        chk("post_rst_quiet", seen, 0);

        // Drive-path table on ch1, one-cycle latency
        for (int i = 0; i < 9; i++) begin
            od_mode[1] = tbl[i].od; oe[1] = tbl[i].oe; out_val[1] = tbl[i].out_val;
            #1;
            if (i > 0) chk($sformatf("drv%0d_hold_en", i), dut.drive_en[1], tbl[i-1].exp_en);
            @(negedge clk);
            chk($sformatf("drv%0d_pad", i), pads[1], tbl[i].exp_pad);
            chk($sformatf("drv%0d_en", i), dut.drive_en[1], tbl[i].exp_en);
            chk($sformatf("drv%0d_val", i), dut.drive_val[1], tbl[i].exp_val);
        end
        od_mode[1] = 1'b1; out_val[1] = 1'b1;
        repeat (12) @(negedge clk);

        // Open-drain on ch0: pull low then release
        out_val[0] = 1'b0;
        @(negedge clk);
        chk("od_pad_low", pads[0], 1'b0);
        watch(0, 13, f_at, f_n, r_at, r_n, both);
        chk("od_fall_at", f_at, SYNC + FILT);
        chk("od_fall_n", f_n, 1);
        chk("od_in_low", in_val[0], 1'b0);
        out_val[0] = 1'b1;
        @(negedge clk);
        chk("od_release_en", dut.drive_en[0], 1'b0);
        chk("od_release_val", dut.drive_val[0], 1'b0);
        watch(0, 13, f_at, f_n, r_at, r_n, both);
        chk("od_rise_at", r_at, SYNC + FILT);
        chk("od_rise_n", r_n, 1);
        chk("od_no_fall", f_n, 0);

        // Glitch filter on ch2: 2-cycle pulse rejected, 3-cycle pulse passed
        for (int len = 2; len <= 3; len++) begin
            f_at = -1; r_at = -1; f_n = 0; r_n = 0; lows = 0;
            for (int k = 0; k < 16; k++) begin
                ext_low[2] = (k < len);
                @(negedge clk);
                if (fall[2]) begin f_n++; if (f_at < 0) f_at = k + 1; end
                if (rise[2]) begin r_n++; if (r_at < 0) r_at = k + 1; end
                if (!in_val[2]) lows++;
            end
            chk($sformatf("glitch%0d_falls", len), f_n, (len == 3) ? 1 : 0);
            chk($sformatf("glitch%0d_rises", len), r_n, (len == 3) ? 1 : 0);
            chk($sformatf("glitch%0d_lowcyc", len), lows, (len == 3) ? 3 : 0);
            if (len == 3) begin
                chk("glitch3_fall_at", f_at, SYNC + FILT);
                chk("glitch3_rise_at", r_at, SYNC + FILT + 3);
            end
        end

        // Stuck detector on ch3
        ext_low[3] = 1'b1;
        seen = -1; set_cnt = 0;
        for (int k = 1; k <= 1040; k++) begin
            @(negedge clk);
            if (stuck[3]) begin set_cnt++; if (seen < 0) seen = k; end
        end
        chk("stuck_set_at", seen, SYNC + FILT + STK);
        chk("stuck_sticky", set_cnt, 1040 - (SYNC + FILT + STK) + 1);
        stuck_clear[3] = 1'b1;
        @(negedge clk);
        stuck_clear[3] = 1'b0;
        chk("stuck_cleared", stuck[3], 1'b0);
        @(negedge clk);
        chk("stuck_reassert", stuck[3], 1'b1);
        ext_low[3] = 1'b0;
        repeat (10) @(negedge clk);
        chk("stuck_line_high", in_val[3], 1'b1);
        chk("stuck_still_set", stuck[3], 1'b1);
        stuck_clear[3] = 1'b1;
        @(negedge clk);
        stuck_clear[3] = 1'b0;
        repeat (5) @(negedge clk);
        chk("stuck_final_clear", stuck[3], 1'b0);

        // Mid-operation reset during a stuck count (ch3) and a filter count (ch2)
        ext_low[3] = 1'b1;
        repeat (15) @(negedge clk);
        ext_low[2] = 1'b1;
        repeat (3) @(negedge clk);
        #2 rstnn = 1'b0;
        #1;
        chk("midrst_in_val", in_val, 4'hF);
        chk("midrst_stuck", stuck, 0);
        chk("midrst_edges", rise | fall, 0);
        ext_low[2] = 1'b0;
        @(negedge clk);
        rstnn = 1'b1;
        seen = -1; set_cnt = -1; lows = 0;
        for (int k = 1; k <= 1040; k++) begin
            @(negedge clk);
            if (!in_val[3] && seen < 0) seen = k;
            if (stuck[3] && set_cnt < 0) set_cnt = k;
            if (!in_val[2] || fall[2]) lows++;
        end
        chk("midrst_fall_restart", seen, SYNC + FILT);
        chk("midrst_stuck_restart", set_cnt, SYNC + FILT + STK);
        chk("midrst_ch2_quiet", lows, 0);

        // Random traffic against the reference model
        ext_low = '0; od_mode = '1; oe = '0; out_val = '1; stuck_clear = '0;
        rstnn = 1'b0;
        repeat (2) @(negedge clk);
        model_init();
        rstnn = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [NCH-1:0] m_pad, nov, nel;
            nel = ext_low;
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 2) == 0) nel[c] = ~ext_low[c];
                nov[c] = ($urandom_range(0, 4) != 0);
                m_pad[c] = !(nel[c] || !prev_out[c]);
                model_step(c, m_pad[c], prev_out[c]);
            end
            ext_low = nel; out_val = nov; prev_out = nov;
            #1;
            chk($sformatf("rnd%0d_pad", cyc), pads, m_pad);
            @(negedge clk);
            chk($sformatf("rnd%0d_in_val", cyc), in_val, m_filt);
            chk($sformatf("rnd%0d_rise", cyc), rise, m_rise);
            chk($sformatf("rnd%0d_fall", cyc), fall, m_fall);
            chk($sformatf("rnd%0d_stuck", cyc), stuck, m_stuck);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
